// File: rtl/parity_frame_checker.sv
// parity_frame_checker
// Serial single-bit-parity frame checker. Bits arrive LSB first, qualified by
// in_valid; 'start' marks data bit 0 of a new frame. The final bit of a frame
// is the parity bit. A running XOR is folded over the frame, and the
// deserialized word is reported together with a parity-error flag.
//
// Optional feature: define PARITY_ERR_COUNT_EN to add the err_count port,
// which is an 8-bit saturating count of frames that had a parity error.

module parity_frame_checker #(
  parameter int DATA_BITS  = 8,  // 1..32
  parameter int PARITY_ODD = 0   // 0 = even parity, 1 = odd parity
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 start,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 out_valid,
  output logic                 parity_err,
  output logic                 busy
`ifdef PARITY_ERR_COUNT_EN
  ,
  output logic [7:0]           err_count
`endif
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  localparam int               CNT_W    = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic             ODD      = (PARITY_ODD != 0);
  // With a single data bit, the bit after start is already the parity bit.
  localparam state_t           FIRST    = (DATA_BITS == 1) ? PARITY : DATA;

  state_t                 state, state_n;
  logic [DATA_BITS-1:0]   sh;
  logic                   acc;
  logic [CNT_W-1:0]       cnt;

  // The parity bit is accepted only when it is not itself a restart.
  logic take_parity;
  assign take_parity = in_valid && !start && (state == PARITY);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every clocked process uses non-blocking (<=) assignments, so all
    // registers update together from values sampled before the edge.
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic. A start bit restarts the frame from any state.
  always_comb begin
    // NOTE: the default assignment comes first, so no path leaves state_n
    // unassigned and no latch is inferred.
    state_n = state;
    if (in_valid) begin
      if (start) begin
        state_n = FIRST;
      end else begin
        unique case (state)
          IDLE:    state_n = IDLE;
          DATA:    if (cnt == CNT_LAST) state_n = PARITY;
          PARITY:  state_n = IDLE;
          default: state_n = IDLE;
        endcase
      end
    end
  end

  // Output decode.
  always_comb begin
    busy = (state != IDLE);
  end

  // Shift register, running XOR and bit counter. All of them freeze while
  // in_valid is low.
  always_ff @(posedge clk) begin
    // NOTE: the shift register is cleared on reset along with the other state,
    // so simulation never sees X values on data_out.
    if (rst) begin
      sh  <= '0;
      acc <= 1'b0;
      cnt <= '0;
    end else if (in_valid) begin
      if (start) begin
        sh[0] <= in_bit;
        acc   <= in_bit;
        cnt   <= CNT_W'(1);
      end else if (state == DATA) begin
        for (int i = 0; i < DATA_BITS; i++) begin
          if (cnt == CNT_W'(i)) sh[i] <= in_bit;
        end
        acc <= acc ^ in_bit;
        cnt <= cnt + 1'b1;
      end else if (state == PARITY) begin
        cnt <= '0;
      end
    end
  end

  // Result registers. out_valid is a one-cycle pulse. data_out and parity_err
  // keep their values until the next completed frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      parity_err <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (take_parity) begin
        data_out   <= sh;
        parity_err <= acc ^ in_bit ^ ODD;
        out_valid  <= 1'b1;
      end
    end
  end

`ifdef PARITY_ERR_COUNT_EN
  // Saturating error counter. It counts during the out_valid cycle of each
  // errored frame and is cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                                            err_count <= 8'd0;
    else if (out_valid && parity_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// Testbench for parity_frame_checker. An even-parity and an odd-parity
// instance (DATA_BITS=8) share the same inputs. Directed vectors hold
// hand-computed expected results.

module tb_parity_frame_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic start = 1'b0;

  logic [7:0] data_e, data_o;
  logic       ov_e, ov_o, perr_e, perr_o, busy_e, busy_o;
`ifdef PARITY_ERR_COUNT_EN
  logic [7:0] err_e, err_o;
`endif

  parity_frame_checker #(.DATA_BITS(8), .PARITY_ODD(0)) dut_even (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .start(start),
    .data_out(data_e), .out_valid(ov_e), .parity_err(perr_e), .busy(busy_e)
`ifdef PARITY_ERR_COUNT_EN
    , .err_count(err_e)
`endif
  );

  parity_frame_checker #(.DATA_BITS(8), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .start(start),
    .data_out(data_o), .out_valid(ov_o), .parity_err(perr_o), .busy(busy_o)
`ifdef PARITY_ERR_COUNT_EN
    , .err_count(err_o)
`endif
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int ov_e_cnt = 0;
  int ov_o_cnt = 0;
  int         o_cyc_q[$];
  logic [7:0] o_dat_q[$];
  logic       o_err_q[$];

  // Free-running cycle counter.
  always @(posedge clk) cyc++;

  // Monitor that counts out_valid pulses and logs odd-instance results.
  always @(negedge clk) begin
    if (ov_e) ov_e_cnt++;
    if (ov_o) begin
      ov_o_cnt++;
      o_cyc_q.push_back(cyc);
      o_dat_q.push_back(data_o);
      o_err_q.push_back(perr_o);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the falling edge, after the monitor has run.
  task automatic drive(input logic v, input logic b, input logic s);
    @(negedge clk);
    #1;
    in_valid = v;
    in_bit   = b;
    start    = s;
  endtask

  // Send one frame: a start bit, 7 more data bits, then the parity bit.
  // Garbage is driven on in_bit/start during each stall gap.
  task automatic send_frame(input logic [7:0] d, input logic p, input int stall);
    drive(1'b1, d[0], 1'b1);
    for (int i = 1; i < 8; i++) begin
      repeat (stall) drive(1'b0, 1'b1, 1'b1);
      drive(1'b1, d[i], 1'b0);
    end
    repeat (stall) drive(1'b0, 1'b1, 1'b1);
    drive(1'b1, p, 1'b0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       exp_err;  // even-parity expectation, computed by hand
  } vec_t;

  vec_t vecs[8];

  initial begin
    int base;

    vecs[0] = '{8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1};
    vecs[2] = '{8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1};
    vecs[5] = '{8'h80, 1'b1, 1'b0};
    vecs[6] = '{8'h7F, 1'b1, 1'b0};
    vecs[7] = '{8'h01, 1'b0, 1'b1};

    // Reset for 2 cycles, then idle for 10 cycles.
    repeat (2) drive(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (10) drive(1'b0, 1'b0, 1'b0);
    check("reset_ov_pulses", ov_e_cnt + ov_o_cnt, 0);
    check("reset_data", data_e, 8'h00);
    check("reset_perr", perr_e, 1'b0);
    check("reset_busy", {busy_e, busy_o}, 2'b00);
`ifdef PARITY_ERR_COUNT_EN
    check("reset_err_count", err_e, 8'd0);
`endif

    // Clean 0xA5 frame: out_valid appears in the cycle right after the parity bit.
    send_frame(8'hA5, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b0);
    check("latency_ov_high", ov_e, 1'b1);
    check("latency_busy_low", busy_e, 1'b0);
    check("clean_data", data_e, 8'hA5);
    check("clean_perr", perr_e, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("latency_ov_one_cycle", ov_e, 1'b0);

    // 0xA5 frame with a parity error.
    send_frame(8'hA5, 1'b1, 0);
    repeat (2) drive(1'b0, 1'b0, 1'b0);
    check("err_perr", perr_e, 1'b1);
`ifdef PARITY_ERR_COUNT_EN
    check("err_count_1", err_e, 8'd1);
`endif

    // Table-driven frames.
    for (int k = 0; k < 8; k++) begin
      base = ov_e_cnt;
      send_frame(vecs[k].data, vecs[k].par, 0);
      repeat (2) drive(1'b0, 1'b0, 1'b0);
      check($sformatf("vec%0d_pulses", k), ov_e_cnt - base, 1);
      check($sformatf("vec%0d_data", k), data_e, vecs[k].data);
      check($sformatf("vec%0d_perr", k), perr_e, vecs[k].exp_err);
    end

    // 0x3C frame with 3 stall cycles between every bit.
    base = ov_e_cnt;
    send_frame(8'h3C, 1'b0, 3);
    repeat (2) drive(1'b0, 1'b0, 1'b0);
    check("stall_pulses", ov_e_cnt - base, 1);
    check("stall_data", data_e, 8'h3C);
    check("stall_perr", perr_e, 1'b0);

    // 0xFF frame aborted by a new start on bit 5; the new frame is 0x0F.
    base = ov_e_cnt;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    check("busy_after_start", busy_e, 1'b1);
    repeat (3) drive(1'b1, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b0, 0);
    repeat (2) drive(1'b0, 1'b0, 1'b0);
    check("abort_pulses", ov_e_cnt - base, 1);
    check("abort_data", data_e, 8'h0F);
    check("abort_perr", perr_e, 1'b0);

    // Reset after 4 bits of a frame: no out_valid, and the held results are cleared.
    base = ov_e_cnt;
    drive(1'b1, 1'b0, 1'b1);
    repeat (3) drive(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    check("midrst_pulses", ov_e_cnt - base, 0);
    check("midrst_busy", busy_e, 1'b0);
    check("midrst_data", data_e, 8'h00);

    // Odd parity, back to back: the second start lands in the first out_valid cycle.
    o_cyc_q.delete(); o_dat_q.delete(); o_err_q.delete();
    send_frame(8'h01, 1'b0, 0);
    send_frame(8'h03, 1'b1, 0);
    repeat (2) drive(1'b0, 1'b0, 1'b0);
    check("b2b_pulses", o_cyc_q.size(), 2);
    if (o_cyc_q.size() == 2) begin
      check("b2b_spacing", o_cyc_q[1] - o_cyc_q[0], 9);
      check("b2b_data0", o_dat_q[0], 8'h01);
      check("b2b_data1", o_dat_q[1], 8'h03);
      check("b2b_perr0", o_err_q[0], 1'b0);
      check("b2b_perr1", o_err_q[1], 1'b0);
    end

`ifdef PARITY_ERR_COUNT_EN
    // 300 error frames: the counter saturates at 255.
    repeat (300) send_frame(8'hA5, 1'b1, 0);
    repeat (2) drive(1'b0, 1'b0, 1'b0);
    check("err_count_sat", err_e, 8'd255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
